// File: rtl/codec_slave_if.sv
// Slave end of the 24-bit serial audio link: oversamples LRCLK/SCLK/SDIN on clk,
// deserializes per-channel RX words, serializes TX words. Define I2S_DELAY_EN for one-SCLK-delayed I2S framing.
module codec_slave_if #(
    parameter int DW        = 24,
    parameter int SLOT_BITS = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i2s_lrclk,
    input  logic          i2s_sclk,
    input  logic          i2s_sdin,
    output logic          i2s_sdout,
    output logic [1:0]    rx_vld,
    output logic [DW-1:0] rx_data,
    output logic [1:0]    tx_ack,
    input  logic [DW-1:0] tx_din0,
    input  logic [DW-1:0] tx_din1,
    output logic          locked,
    output logic          frame_err
);

`ifdef I2S_DELAY_EN
    localparam int OFFS = 1;
`else
    localparam int OFFS = 0;
`endif
    localparam int TXW = DW + OFFS;

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_SYNC     = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    localparam logic [5:0] C_SLOT = 6'(SLOT_BITS);
    localparam logic [5:0] C_LAST = 6'(DW - 1 + OFFS);

    logic [2:0]     r_lr_sync;
    logic [2:0]     r_sck_sync;
    logic [1:0]     r_sd_sync;
    logic [1:0]     r_state;
    logic [5:0]     r_bit_cnt;
    logic           r_ch;
    logic [DW-2:0]  r_shr_rx;
    logic [TXW-1:0] r_shr_tx;
    logic [DW-1:0]  r_rx_data;
    logic [1:0]     r_rx_vld;
    logic [1:0]     r_tx_ack;
    logic           r_locked;
    logic           r_frame_err;

    logic           w_slot_start;
    logic           w_ch;
    logic           w_rise;
    logic           w_fall;
    logic           w_sdin;
    logic           w_rx_win;
    logic [1:0]     w_state_nxt;
    logic           w_ferr_nxt;
    logic           w_slot_lock;
    logic [DW-1:0]  w_tx_word;
    logic [TXW-1:0] w_tx_load;

    // Input synchronizers; identical depth keeps coincident pin edges aligned.
    always_ff @(posedge clk) begin
        r_lr_sync  <= {r_lr_sync[1:0], i2s_lrclk};
        r_sck_sync <= {r_sck_sync[1:0], i2s_sclk};
        r_sd_sync  <= {r_sd_sync[0], i2s_sdin};
    end

    // A slot start swallows any SCLK edge detected in the same cycle.
    assign w_slot_start = r_lr_sync[1] ^ r_lr_sync[2];
    assign w_ch         = r_lr_sync[1];
    assign w_rise       = ~w_slot_start & r_sck_sync[1] & ~r_sck_sync[2];
    assign w_fall       = ~w_slot_start & ~r_sck_sync[1] & r_sck_sync[2];
    assign w_sdin       = r_sd_sync[1];
    assign w_tx_word    = w_ch ? tx_din1 : tx_din0;

`ifdef I2S_DELAY_EN
    assign w_rx_win  = (r_bit_cnt != 6'd0) && (r_bit_cnt <= 6'(DW));
    assign w_tx_load = {1'b0, w_tx_word};
`else
    assign w_rx_win  = (r_bit_cnt < 6'(DW));
    assign w_tx_load = w_tx_word;
`endif

    // Framing FSM next state, evaluated only at slot boundaries.
    always_comb begin
        w_state_nxt = r_state;
        w_ferr_nxt  = 1'b0;
        if (w_slot_start) begin
            case (r_state)
                ST_UNLOCKED: w_state_nxt = ST_SYNC;
                ST_SYNC: begin
                    if (r_bit_cnt == C_SLOT) w_state_nxt = ST_LOCKED;
                    else                     w_state_nxt = ST_SYNC;
                end
                ST_LOCKED: begin
                    if (r_bit_cnt == C_SLOT) begin
                        w_state_nxt = ST_LOCKED;
                    end else begin
                        w_state_nxt = ST_SYNC;
                        w_ferr_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = ST_UNLOCKED;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // The slot just starting is serviced only if it begins in LOCKED.
    assign w_slot_lock = (w_state_nxt == ST_LOCKED);

    // Slot datapath, status and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_UNLOCKED;
            r_bit_cnt   <= 6'd0;
            r_ch        <= 1'b0;
            r_shr_rx    <= '0;
            r_shr_tx    <= '0;
            r_rx_data   <= '0;
            r_rx_vld    <= 2'b00;
            r_tx_ack    <= 2'b00;
            r_locked    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_locked    <= w_slot_lock;
            r_frame_err <= w_ferr_nxt;
            r_rx_vld    <= 2'b00;
            r_tx_ack    <= 2'b00;
            if (w_slot_start) begin
                r_bit_cnt <= 6'd0;
                r_ch      <= w_ch;
                r_shr_tx  <= w_slot_lock ? w_tx_load : '0;
                if (w_slot_lock) r_tx_ack <= w_ch ? 2'b10 : 2'b01;
            end else begin
                if (w_fall) r_shr_tx <= {r_shr_tx[TXW-2:0], 1'b0};
                if (w_rise) begin
                    if (r_bit_cnt != 6'd63) r_bit_cnt <= r_bit_cnt + 6'd1;
                    if (w_rx_win) r_shr_rx <= {r_shr_rx[DW-3:0], w_sdin};
                    if (r_bit_cnt == C_LAST) begin
                        r_rx_data <= {r_shr_rx, w_sdin};
                        if (r_state == ST_LOCKED) r_rx_vld <= r_ch ? 2'b10 : 2'b01;
                    end
                end
            end
        end
    end

    assign i2s_sdout = r_shr_tx[TXW-1];
    assign rx_vld    = r_rx_vld;
    assign rx_data   = r_rx_data;
    assign tx_ack    = r_tx_ack;
    assign locked    = r_locked;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_codec_slave_if.sv
// Bench for codec_slave_if: a master model drives slots with random words while a
// scoreboard checks rx/ack/frame_err events against a slot-level lock model.
module tb_codec_slave_if;
    localparam int DW = 24;
`ifdef I2S_DELAY_EN
    localparam int OFFS = 1;
`else
    localparam int OFFS = 0;
`endif
    localparam int NSLOT = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lrclk = 1'b1;
    logic          sclk = 1'b1;
    logic          sdin = 1'b0;
    logic          sdout;
    logic [1:0]    rx_vld;
    logic [DW-1:0] rx_data;
    logic [1:0]    tx_ack;
    logic [DW-1:0] tx_din0 = '0;
    logic [DW-1:0] tx_din1 = '0;
    logic          locked;
    logic          frame_err;

    int checks = 0;
    int errors = 0;

    logic [24:0] rx_q[$];
    logic        ack_q[$];
    logic [24:0] mon_rx;
    logic        mon_ack;
    int          exp_ferr = 0;
    int          seen_ferr = 0;
    int          prev_n = -1;
    bit          prev_lk = 1'b0;

    codec_slave_if #(.DW(DW), .SLOT_BITS(32)) dut (
        .clk(clk), .rst(rst),
        .i2s_lrclk(lrclk), .i2s_sclk(sclk), .i2s_sdin(sdin), .i2s_sdout(sdout),
        .rx_vld(rx_vld), .rx_data(rx_data), .tx_ack(tx_ack),
        .tx_din0(tx_din0), .tx_din1(tx_din1),
        .locked(locked), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rx_vld != 2'b00) begin
            if (rx_q.size() == 0) begin
                chk("rx_vld_unexpected", 64'(rx_vld), 64'd0);
            end else begin
                mon_rx = rx_q.pop_front();
                chk("rx_vld", 64'(rx_vld), mon_rx[24] ? 64'd2 : 64'd1);
                chk("rx_data", 64'(rx_data), 64'(mon_rx[23:0]));
            end
        end
        if (tx_ack != 2'b00) begin
            if (ack_q.size() == 0) begin
                chk("tx_ack_unexpected", 64'(tx_ack), 64'd0);
            end else begin
                mon_ack = ack_q.pop_front();
                chk("tx_ack", 64'(tx_ack), mon_ack ? 64'd2 : 64'd1);
            end
        end
        if (frame_err) begin
            seen_ferr++;
            chk("locked_after_ferr", 64'(locked), 64'd0);
        end
    end

    // One slot as seen by the master; a slot is serviced iff its predecessor was a full 32-SCLK slot.
    task automatic send_slot(input logic ch, input logic [23:0] mword, input logic [23:0] tword,
                             input int nbits, input int rst_at);
        logic [63:0] cap;
        logic [63:0] expc;
        bit lk;
        int idx;
        cap  = '0;
        expc = '0;
        lk   = (prev_n == 32);
        if (prev_lk && prev_n != 32) exp_ferr++;
        if (lk) ack_q.push_back(ch);
        if (lk && rst_at < 0 && nbits >= DW + OFFS) rx_q.push_back({ch, mword});
        for (int b = 0; b < nbits; b++) begin
            @(negedge clk);
            sclk = 1'b0;
            if (b == 0) begin
                lrclk = ch;
                if (ch) tx_din1 = tword;
                else    tx_din0 = tword;
            end
            idx = b - OFFS;
            if (idx >= 0 && idx < DW) sdin = mword[DW-1-idx];
            else                      sdin = 1'($urandom_range(1));
            if (lk && idx >= 0 && idx < DW) expc[b] = tword[DW-1-idx];
            for (int c = 0; c < 7; c++) begin
                @(negedge clk);
                if (b == rst_at && c == 0) rst = 1'b1;
                if (b == rst_at && c == 3) rst = 1'b0;
                if (b == rst_at && c == 5) begin
                    chk("sdout_after_rst", 64'(sdout), 64'd0);
                    chk("locked_after_rst", 64'(locked), 64'd0);
                end
            end
            @(negedge clk);
            cap[b] = sdout;
            sclk = 1'b1;
            if (b == 16) chk("locked_mid_slot", 64'(locked), (rst_at >= 0 && b > rst_at) ? 64'd0 : 64'(lk));
            repeat (8) @(negedge clk);
        end
        if (rst_at < 0) chk($sformatf("sdout_word_ch%0d", ch), cap, expc);
        prev_lk = (rst_at < 0) ? lk : 1'b0;
        prev_n  = (rst_at < 0) ? nbits : -1;
    endtask

    int nb[NSLOT] = '{32, 32, 32, 32, 32, 32, 30, 32, 32, 32,
                      32, 40, 32, 32, 32, 31, 32, 32, 32, 32};
    int ra[NSLOT] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1,
                      -1, -1, -1, -1, 10, -1, -1, -1, -1, -1};

    initial begin
        logic [23:0] mw;
        logic [23:0] tw;
        logic        ch;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sclk = ~sclk;
        end
        rst  = 1'b0;
        sclk = 1'b1;
        chk("rst_sdout", 64'(sdout), 64'd0);
        chk("rst_rx_vld", 64'(rx_vld), 64'd0);
        chk("rst_rx_data", 64'(rx_data), 64'd0);
        chk("rst_tx_ack", 64'(tx_ack), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        for (int i = 0; i < 4; i++) begin
            repeat (8) @(negedge clk);
            sclk = 1'b0;
            repeat (8) @(negedge clk);
            sclk = 1'b1;
        end
        chk("locked_idle", 64'(locked), 64'd0);
        for (int i = 0; i < NSLOT; i++) begin
            ch = 1'(i % 2);
            if (i < 6) begin
                mw = ch ? 24'h123456 : ((OFFS != 0) ? 24'hC00003 : 24'hA5A5A5);
                tw = ch ? 24'h7FFFFE : 24'h800001;
            end else begin
                mw = 24'($urandom);
                tw = (ra[i] >= 0) ? 24'hFFFFFF : 24'($urandom);
            end
            send_slot(ch, mw, tw, nb[i], ra[i]);
        end
        repeat (40) @(negedge clk);
        chk("rx_queue_drained", 64'(rx_q.size()), 64'd0);
        chk("ack_queue_drained", 64'(ack_q.size()), 64'd0);
        chk("frame_err_count", 64'(seen_ferr), 64'(exp_ferr));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
